// File: rtl/xb_oport.sv
// Crossbar output port: switch-traversal register plus per-VC
// downstream credit tracking and sticky protocol-error flags.
module xb_oport #(
  parameter int DW    = 32,
  parameter int V     = 4,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   data_in,
  input  logic            valid_in,
  input  logic [V-1:0]    vc_in,
  input  logic [V-1:0]    credit_in,
  output logic [DW-1:0]   data_out,
  output logic            valid_out,
  output logic [V-1:0]    vc_out,
  output logic [V-1:0]    credit_avail,
  output logic [V*CW-1:0] credit_cnt,
  output logic            err_nocredit,
  output logic            err_overflow,
  output logic            err_vc
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] r_cnt [V];
  logic [CW-1:0] w_cnt_nxt [V];
  logic [DW-1:0] r_data;
  logic [V-1:0]  r_vc;
  logic          r_valid;
  logic          r_err_nc;
  logic          r_err_ov;
  logic          r_err_vc;

  logic          w_onehot;
  logic          w_has_cr;
  logic          w_accept;
  logic [V-1:0]  w_send;
  logic [V-1:0]  w_full;
  logic          w_ovf;

  // Decode the incoming tag and decide whether the flit may go out.
  always_comb begin
    w_onehot = (vc_in != '0) && ((vc_in & (vc_in - V'(1))) == '0);
    w_has_cr = |(vc_in & credit_avail);
    w_accept = valid_in && w_onehot && w_has_cr;
    w_send   = w_accept ? vc_in : '0;
  end

  // Per-VC counter update; a send and a return on one VC cancel out,
  // and a return into a full counter saturates and flags overflow.
  always_comb begin
    w_ovf = 1'b0;
    for (int i = 0; i < V; i++) begin
      w_full[i]    = (r_cnt[i] == FULL);
      w_cnt_nxt[i] = r_cnt[i];
      if (w_send[i] && !credit_in[i])
        w_cnt_nxt[i] = r_cnt[i] - CW'(1);
      else if (credit_in[i] && !w_send[i]) begin
        if (w_full[i]) w_ovf = 1'b1;
        else w_cnt_nxt[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  // Switch-traversal register: payload holds when idle, valid qualifies.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_vc    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_data <= data_in;
        r_vc   <= vc_in;
      end
    end
  end

  // Credit counters, restored to full on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < V; i++) r_cnt[i] <= FULL;
    end else begin
      for (int i = 0; i < V; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_nc <= 1'b0;
      r_err_ov <= 1'b0;
      r_err_vc <= 1'b0;
    end else begin
      if (valid_in && w_onehot && !w_has_cr) r_err_nc <= 1'b1;
      if (w_ovf) r_err_ov <= 1'b1;
      if (valid_in && !w_onehot) r_err_vc <= 1'b1;
    end
  end

  // Publish counters and availability straight from the registers.
  always_comb begin
    for (int i = 0; i < V; i++) begin
      credit_avail[i]          = (r_cnt[i] != '0);
      credit_cnt[i*CW +: CW]   = r_cnt[i];
    end
  end

  assign data_out     = r_data;
  assign vc_out       = r_vc;
  assign valid_out    = r_valid;
  assign err_nocredit = r_err_nc;
  assign err_overflow = r_err_ov;
  assign err_vc       = r_err_vc;

endmodule

// File: tb/tb_xb_oport.sv
// Directed bench for xb_oport: sends, credit loop, errors, reset.
module tb_xb_oport;

  localparam int DW = 32;
  localparam int V  = 4;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   data_in;
  logic            valid_in;
  logic [V-1:0]    vc_in;
  logic [V-1:0]    credit_in;
  logic [DW-1:0]   data_out;
  logic            valid_out;
  logic [V-1:0]    vc_out;
  logic [V-1:0]    credit_avail;
  logic [V*CW-1:0] credit_cnt;
  logic            err_nocredit;
  logic            err_overflow;
  logic            err_vc;

  int checks = 0;
  int errors = 0;

  xb_oport #(.DW(DW), .V(V), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .valid_in(valid_in), .vc_in(vc_in),
    .credit_in(credit_in),
    .data_out(data_out), .valid_out(valid_out), .vc_out(vc_out),
    .credit_avail(credit_avail), .credit_cnt(credit_cnt),
    .err_nocredit(err_nocredit), .err_overflow(err_overflow),
    .err_vc(err_vc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int i);
    return credit_cnt[i*CW +: CW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [V-1:0] vc,
                       input logic [DW-1:0] d, input logic [V-1:0] cr);
    valid_in  = v;
    vc_in     = vc;
    data_in   = d;
    credit_in = cr;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_cnt", credit_cnt, 12'h924);
    chk("rst_avail", credit_avail, 4'b1111);
    chk("rst_errs", {err_nocredit, err_overflow, err_vc}, 3'b000);
    chk("rst_data", data_out, 32'h0);

    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'b0100, 32'hA0 + k, '0);
      tick();
      chk("b2b_valid", valid_out, 1'b1);
      chk("b2b_data", data_out, 32'hA0 + k);
      chk("b2b_vc", vc_out, 4'b0100);
      chk("b2b_cnt2", cnt(2), 3 - k);
    end
    chk("b2b_avail", credit_avail, 4'b1011);

    drive(1'b1, 4'b0100, 32'hA4, '0);
    tick();
    chk("nc_valid", valid_out, 1'b0);
    chk("nc_cnt2", cnt(2), 3'd0);
    chk("nc_err", err_nocredit, 1'b1);
    drive(1'b0, '0, 32'hFF, '0);
    tick();
    chk("nc_sticky", err_nocredit, 1'b1);
    chk("hold_data", data_out, 32'hA3);
    chk("hold_vc", vc_out, 4'b0100);

    drive(1'b1, 4'b0010, 32'hB0, '0);
    tick();
    drive(1'b1, 4'b0010, 32'hB1, '0);
    tick();
    drive(1'b1, 4'b1000, 32'hB2, '0);
    tick();
    chk("pre_cnt1", cnt(1), 3'd2);
    chk("pre_cnt3", cnt(3), 3'd3);

    drive(1'b1, 4'b0010, 32'hB3, 4'b0010);
    tick();
    chk("same_cnt1", cnt(1), 3'd2);
    chk("same_valid", valid_out, 1'b1);
    chk("same_data", data_out, 32'hB3);
    chk("same_errs", {err_overflow, err_vc}, 2'b00);

    drive(1'b0, '0, '0, 4'b1111);
    tick();
    chk("ovf_cnt0", cnt(0), 3'd4);
    chk("ovf_err", err_overflow, 1'b1);
    chk("ovf_cnt1", cnt(1), 3'd3);
    chk("ovf_cnt2", cnt(2), 3'd1);
    chk("ovf_cnt3", cnt(3), 3'd4);
    chk("ovf_valid", valid_out, 1'b0);

    drive(1'b1, 4'b0011, 32'hC0, '0);
    tick();
    chk("vc2_valid", valid_out, 1'b0);
    chk("vc2_err", err_vc, 1'b1);
    chk("vc2_cnt", credit_cnt, {3'd4, 3'd1, 3'd3, 3'd4});
    drive(1'b1, 4'b0000, 32'hC1, '0);
    tick();
    chk("vc0_valid", valid_out, 1'b0);
    chk("vc0_cnt", credit_cnt, {3'd4, 3'd1, 3'd3, 3'd4});
    chk("vc0_data", data_out, 32'hB3);

    drive(1'b1, 4'b1000, 32'hD0, '0);
    tick();
    drive(1'b1, 4'b1000, 32'hD1, '0);
    tick();
    chk("mid_cnt3", cnt(3), 3'd2);
    chk("mid_valid", valid_out, 1'b1);
    rst = 1'b1;
    drive(1'b1, 4'b1000, 32'hD2, '0);
    tick();
    rst = 1'b0;
    chk("mrst_valid", valid_out, 1'b0);
    chk("mrst_cnt3", cnt(3), 3'd4);
    chk("mrst_cnt", credit_cnt, 12'h924);
    chk("mrst_errs", {err_nocredit, err_overflow, err_vc}, 3'b000);
    chk("mrst_data", data_out, 32'h0);
    drive(1'b1, 4'b1000, 32'hE0, '0);
    tick();
    chk("post_valid", valid_out, 1'b1);
    chk("post_data", data_out, 32'hE0);
    chk("post_cnt3", cnt(3), 3'd3);
    drive(1'b0, '0, '0, '0);
    tick();
    chk("post_idle", valid_out, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xb_oport.md
# xb_oport

Output port stage of the crossbar, the downstream counterpart of the per-input-port VC multiplexing stage. It takes the single flit the main crossbar delivers to this output port, tagged with its one-hot downstream VC, and registers it onto the outgoing link (switch-traversal register). It keeps one credit counter per downstream VC and publishes per-VC credit availability to the allocators. It flags protocol violations: sends without credit, credit overflow, and malformed VC tags.

## Interface
Parameters:
- DW, 32, flit data width
- V, 4, number of downstream VCs
- DEPTH, 4, downstream buffer depth per VC (flits); credit counters reset to this value
- CW, $clog2(DEPTH+1), credit counter width (derived, not overridden)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- data_in  input  DW  flit from main crossbar
- valid_in  input  1  flit present this cycle
- vc_in  input  V  one-hot downstream VC of the flit (sampled only when valid_in=1)
- credit_in  input  V  credit return pulses from downstream, one bit per VC; any combination may be set in one cycle
- data_out  output  DW  registered flit to link
- valid_out  output  1  registered flit valid
- vc_out  output  V  registered one-hot VC tag
- credit_avail  output  V  bit i = 1 when credit counter i is nonzero
- credit_cnt  output  V*CW  flattened counters, VC i at [i*CW +: CW]
- err_nocredit  output  1  sticky: flit dropped for zero credit
- err_overflow  output  1  sticky: credit returned to a full counter
- err_vc  output  1  sticky: valid_in with vc_in not one-hot

## Operation
- Accept condition: valid_in=1, vc_in one-hot, cnt[vc]>0.
- Accepted flit:
  - next cycle data_out=data_in, vc_out=vc_in, valid_out=1
  - cnt[vc] decremented, unless credit_in[vc]=1 the same cycle (net unchanged)
- Rejected flit, zero credit: valid_out=0 next cycle; counters not decremented; err_nocredit set.
- Rejected flit, vc_in not one-hot (zero or multiple bits): flit dropped; err_vc set; no counter decremented.
- No flit (valid_in=0):
  - valid_out=0 next cycle
  - data_out and vc_out hold their previous values; only valid_out qualifies them
- Credit return, per VC i, independent of other VCs:
  - credit_in[i]=1 increments cnt[i], except as below.
  - If cnt[i]=DEPTH and no same-cycle accepted send to VC i: increment is ignored (cnt[i] stays DEPTH) and err_overflow is set.
  - Simultaneous send and credit on the same VC is never an overflow.
- Counter width: counters never wrap; they saturate at 0 and DEPTH.
- credit_avail and credit_cnt are driven combinationally from the counter registers. They reflect updates the cycle after the triggering event.
- Error flags stay 1 until rst.
- Reset: rst=1 at a clock edge sets:
  - valid_out=0, data_out=0, vc_out=0
  - all cnt=DEPTH, so credit_avail=all ones
  - all err flags=0
- Reset mid-operation: an in-flight registered flit is discarded, and credits are restored to DEPTH regardless of outstanding flits. Reset is not ordered with downstream; downstream reset is coordinated by the system.

## Timing
- Latency: data_in to data_out is exactly 1 cycle; no bubbles, so one flit per cycle is sustained.
- Credit loop:
  - A send in cycle t is visible on credit_cnt and credit_avail in cycle t+1.
  - A credit_in in cycle t is visible in cycle t+1.
- The allocators must use credit_avail from the current cycle.
- A sender that issues a flit to a VC whose credit_avail=1 with cnt=1 must not issue another to the same VC in the same cycle; the port accepts one flit per cycle by construction.
- No backpressure signal: the link is credit-based, and dropping is an error condition, never flow control.

## Test plan
- Reset, then idle 3 cycles. Required: valid_out=0, credit_cnt = 4 for every VC, credit_avail=4'b1111, all err=0.
- 4 back-to-back flits to VC2 (vc_in=4'b0100, data 0xA0..0xA3):
  - data_out shows 0xA0..0xA3 on cycles 1..4 with valid_out=1
  - cnt2 goes 3,2,1,0
  - credit_avail=4'b1011 after the 4th flit
- Continuing from the previous case, a 5th flit 0xA4 to VC2. Required: valid_out=0 next cycle, cnt2 stays 0, err_nocredit=1 and it stays set.
- VC1 with cnt1=2: send to VC1 with credit_in=4'b0010 in the same cycle. Required: cnt1 stays 2, valid_out=1, no errors. Also credit_in=4'b1111 with VC0 full (cnt0=4). Required: cnt0 stays 4, err_overflow=1, other VCs increment.
- valid_in=1 with vc_in=4'b0011 or vc_in=4'b0000. Required: flit dropped, err_vc=1, counters unchanged.
- Assert rst mid-stream, after VC3 has 2 flits outstanding. Required: next cycle valid_out=0, cnt3=4, err flags cleared; a subsequent send to VC3 is accepted normally.
